// File: rtl/decode_stage.sv
// RV32I decode: register file read, immediate/control generation, ID/EX pipeline register.
// Latency: 1 cycle from instr_in to *_ex outputs.
// Backpressure: stall_fe (combinational load-use hazard) holds fetch and injects a bubble; WB_BYPASS_EN adds write-through.
module decode_stage #(
    parameter logic [31:0] NOP_INSN  = 32'h0000_0013,
    parameter logic [6:0]  CUSTOM_OP = 7'b000_1011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_fe,
    output logic [31:0] pc_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rd_ex,
    output logic [3:0]  alu_op_ex,
    output logic        alu_src_ex,
    output logic        mem_rd_ex,
    output logic        mem_wr_ex,
    output logic [2:0]  funct3_ex,
    output logic        branch_ex,
    output logic        jump_ex,
    output logic        rti_ex,
    output logic        rsi_ex
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  funct3;
        logic        branch;
        logic        jump;
        logic        rti;
        logic        rsi;
    } idex_t;

    logic [31:0] rf [32];
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic        uses_rs1, uses_rs2, legal;
    idex_t       dec, idex;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign funct3 = instr_in[14:12];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign alt    = instr_in[30];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    // x0 is never written; its reads are forced to zero below
    always_ff @(posedge clk) begin
        if (wb_en && wb_rd != 5'd0)
            rf[wb_rd] <= wb_data;
    end

    always_comb begin
        rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd == rs1 && rs1 != 5'd0)
            rs1_val = wb_data;
        if (wb_en && wb_rd == rs2 && rs2 != 5'd0)
            rs2_val = wb_data;
`endif
    end

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt_bit, input logic is_reg);
        case (f3)
            3'b000:  alu_sel = (is_reg && alt_bit) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt_bit ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec        = '0;
        dec.pc     = pc_in;
        dec.rs1    = rs1_val;
        dec.rs2    = rs2_val;
        dec.funct3 = funct3;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        legal      = 1'b1;
        case (opcode)
            OP_LUI: begin
                dec.rd = rd; dec.imm = imm_u; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1; dec.funct3 = 3'b000;
            end
            // execute selects pc as operand A on funct3=111 with jump=0
            OP_AUIPC: begin
                dec.rd = rd; dec.imm = imm_u; dec.alu_src = 1'b1; dec.funct3 = 3'b111;
            end
            OP_JAL: begin
                dec.rd = rd; dec.imm = imm_j; dec.alu_src = 1'b1; dec.jump = 1'b1; dec.funct3 = 3'b000;
            end
            OP_JALR: begin
                dec.rd = rd; dec.imm = imm_i; dec.alu_src = 1'b1; dec.jump = 1'b1; uses_rs1 = 1'b1;
            end
            // ALU compares by subtraction; funct3 carries the condition
            OP_BRANCH: begin
                dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                dec.rd = rd; dec.imm = imm_i; dec.alu_src = 1'b1; dec.mem_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                dec.rd = rd; dec.imm = imm_i; dec.alu_src = 1'b1; dec.alu_op = alu_sel(funct3, alt, 1'b0);
                uses_rs1 = 1'b1;
            end
            OP_REG: begin
                dec.rd = rd; dec.alu_op = alu_sel(funct3, alt, 1'b1); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            CUSTOM_OP: begin
                dec.funct3 = 3'b000;
                dec.rti    = (funct3 == 3'b000);
                dec.rsi    = (funct3 == 3'b001);
                legal      = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: legal = 1'b0;
        endcase
        if (!legal || instr_in == NOP_INSN) begin
            dec      = '0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

    assign stall_fe = idex.mem_rd && (idex.rd != 5'd0) &&
                      ((idex.rd == rs1 && uses_rs1) || (idex.rd == rs2 && uses_rs2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idex <= '0;
        else if (flush || stall_fe)
            idex <= '0;
        else
            idex <= dec;
    end

    assign pc_ex       = idex.pc;
    assign rs1_data_ex = idex.rs1;
    assign rs2_data_ex = idex.rs2;
    assign imm_ex      = idex.imm;
    assign rd_ex       = idex.rd;
    assign alu_op_ex   = idex.alu_op;
    assign alu_src_ex  = idex.alu_src;
    assign mem_rd_ex   = idex.mem_rd;
    assign mem_wr_ex   = idex.mem_wr;
    assign funct3_ex   = idex.funct3;
    assign branch_ex   = idex.branch;
    assign jump_ex     = idex.jump;
    assign rti_ex      = idex.rti;
    assign rsi_ex      = idex.rsi;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a field-level reference decoder and register file model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in, pc_in, wb_data;
    logic        flush, wb_en;
    logic [4:0]  wb_rd;
    logic        stall_fe;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rd_ex;
    logic [3:0]  alu_op_ex;
    logic        alu_src_ex, mem_rd_ex, mem_wr_ex;
    logic [2:0]  funct3_ex;
    logic        branch_ex, jump_ex, rti_ex, rsi_ex;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_fe(stall_fe),
        .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .rd_ex(rd_ex), .alu_op_ex(alu_op_ex), .alu_src_ex(alu_src_ex), .mem_rd_ex(mem_rd_ex),
        .mem_wr_ex(mem_wr_ex), .funct3_ex(funct3_ex), .branch_ex(branch_ex), .jump_ex(jump_ex),
        .rti_ex(rti_ex), .rsi_ex(rsi_ex)
    );

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_rd, mem_wr;
        logic [2:0]  funct3;
        logic        branch, jump, rti, rsi;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q;
    logic [31:0] ref_rf [32];
    logic        seen_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc"},  pc_ex, exp_q.pc);
        check({tag, ".rs1"}, rs1_data_ex, exp_q.rs1);
        check({tag, ".rs2"}, rs2_data_ex, exp_q.rs2);
        check({tag, ".imm"}, imm_ex, exp_q.imm);
        check({tag, ".rd"},  {27'd0, rd_ex}, {27'd0, exp_q.rd});
        check({tag, ".alu"}, {28'd0, alu_op_ex}, {28'd0, exp_q.alu_op});
        check({tag, ".ctl"},
              {22'd0, alu_src_ex, mem_rd_ex, mem_wr_ex, funct3_ex, branch_ex, jump_ex, rti_ex, rsi_ex},
              {22'd0, exp_q.alu_src, exp_q.mem_rd, exp_q.mem_wr, exp_q.funct3, exp_q.branch,
               exp_q.jump, exp_q.rti, exp_q.rsi});
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r, input bit we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && wa == r) return wd;
`endif
        return ref_rf[r];
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input bit is_reg);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && is_reg && b30) return 4'd1;
        if (f3 == 3'd5 && b30) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input bit we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] ii;
        int          bimm, jimm;
        ii   = $signed(ins) >>> 20;
        bimm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - (ins[31] ? 4096 : 0);
        jimm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096 - (ins[31] ? 1048576 : 0);
        e = '0;
        if (ins == 32'h0000_0013) return e;
        e.pc     = pc;
        e.rs1    = rf_read(ins[19:15], we, wa, wd);
        e.rs2    = rf_read(ins[24:20], we, wa, wd);
        e.funct3 = ins[14:12];
        case (ins[6:0])
            7'h37: begin e.rd = ins[11:7]; e.imm = ins & 32'hFFFF_F000; e.alu_op = 4'd10; e.alu_src = 1; e.funct3 = 0; end
            7'h17: begin e.rd = ins[11:7]; e.imm = ins & 32'hFFFF_F000; e.alu_src = 1; e.funct3 = 3'b111; end
            7'h6F: begin e.rd = ins[11:7]; e.imm = jimm; e.alu_src = 1; e.jump = 1; e.funct3 = 0; end
            7'h67: begin e.rd = ins[11:7]; e.imm = ii; e.alu_src = 1; e.jump = 1; end
            7'h63: begin e.imm = bimm; e.alu_op = 4'd1; e.branch = 1; end
            7'h03: begin e.rd = ins[11:7]; e.imm = ii; e.alu_src = 1; e.mem_rd = 1; end
            7'h23: begin e.imm = (ii & 32'hFFFF_FFE0) | {27'd0, ins[11:7]}; e.alu_src = 1; e.mem_wr = 1; end
            7'h13: begin e.rd = ins[11:7]; e.imm = ii; e.alu_src = 1; e.alu_op = ref_alu(ins[14:12], ins[30], 0); end
            7'h33: begin e.rd = ins[11:7]; e.alu_op = ref_alu(ins[14:12], ins[30], 1); end
            7'h0B: begin
                if (ins[14:12] == 3'd0) e.rti = 1;
                else if (ins[14:12] == 3'd1) e.rsi = 1;
                else return '0;
                e.funct3 = 0;
            end
            default: return '0;
        endcase
        return e;
    endfunction

    function automatic bit model_stall(input logic [31:0] ins);
        bit u1, u2;
        u1 = ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33} && ins != 32'h13;
        u2 = ins[6:0] inside {7'h63, 7'h23, 7'h33};
        return exp_q.mem_rd && exp_q.rd != 0 &&
               ((u1 && ins[19:15] == exp_q.rd) || (u2 && ins[24:20] == exp_q.rd));
    endfunction

    // One decode cycle: drive, check the hazard output, clock, check ID/EX against the model.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input bit fl, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd, input string tag, output bit st);
        exp_t nxt;
        instr_in = ins; pc_in = pc; flush = fl; wb_en = we; wb_rd = wa; wb_data = wd;
        #1;
        st = model_stall(ins);
        seen_stall = stall_fe;
        check({tag, ".stall"}, {31'd0, stall_fe}, {31'd0, st});
        nxt = (fl || st) ? exp_t'('0) : model_decode(ins, pc, we, wa, wd);
        if (we && wa != 5'd0) ref_rf[wa] = wd;
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  ops [13];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B, 7'h73, 7'h0F, 7'h7F};
        if ($urandom_range(0, 15) == 0) return 32'h0000_0013;
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 12)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (w[6:0] == 7'h0B) w[14:12] = 3'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          st, hold;
        logic [31:0] cur_ins, cur_pc, lw7, add8;
        lw7  = enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd7, 7'h03);
        add8 = enc(7'd0, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33);
        rst_n = 0; instr_in = 0; pc_in = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        #3;
        exp_q = '0;
        check_outputs("reset");
        check("reset.stall", {31'd0, stall_fe}, 32'd0);
        #4 rst_n = 1;
        @(posedge clk); #1;

        step(32'h0000_0013, 32'h40, 0, 0, 0, 0, "t1_nop", st);
        check("t1_alu_add", {28'd0, alu_op_ex}, 32'd0);
        for (int r = 1; r < 32; r++)
            step(32'h0000_0013, 32'h44, 0, 1, 5'(r), $urandom, "init", st);

        step(32'h0000_0013, 32'h80, 0, 1, 5'd5, 32'hDEAD_BEEF, "t2_wb", st);
        step(32'hFFF2_8313, 32'h84, 0, 0, 0, 0, "t2_addi", st);
        check("t2_rs1", rs1_data_ex, 32'hDEAD_BEEF);
        check("t2_imm", imm_ex, 32'hFFFF_FFFF);
        check("t2_rd", {27'd0, rd_ex}, 32'd6);
        check("t2_alu_src", {31'd0, alu_src_ex}, 32'd1);

        rst_n = 0; #1;
        exp_q = '0;
        check_outputs("areset");
        rst_n = 1;

        step(lw7, 32'h100, 0, 0, 0, 0, "t3_lw", st);
        step(add8, 32'h104, 0, 0, 0, 0, "t3_stall", st);
        check("t3_stall_seen", {31'd0, seen_stall}, 32'd1);
        check("t3_bubble_rd", {27'd0, rd_ex}, 32'd0);
        step(add8, 32'h104, 0, 0, 0, 0, "t3_add", st);
        check("t3_nostall", {31'd0, seen_stall}, 32'd0);
        check("t3_add_rd", {27'd0, rd_ex}, 32'd8);

        step(32'hFE20_8CE3, 32'h200, 0, 0, 0, 0, "t4_beq", st);
        check("t4_branch", {31'd0, branch_ex}, 32'd1);
        check("t4_imm", imm_ex, 32'hFFFF_FFF8);
        step(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33), 32'h204, 1, 0, 0, 0, "t4_flush", st);
        check("t4_flush_rd", {27'd0, rd_ex}, 32'd0);
        check("t4_flush_pc", pc_ex, 32'd0);
        step(lw7, 32'h208, 0, 0, 0, 0, "t4_lw", st);
        step(add8, 32'h20C, 1, 0, 0, 0, "t4_flush_stall", st);
        step(add8, 32'h300, 0, 0, 0, 0, "t4_after", st);
        check("t4_hazard_cleared", {31'd0, seen_stall}, 32'd0);

        step(32'h0000_0013, 32'h400, 0, 1, 5'd3, 32'h1111_1111, "t5_old", st);
        step(enc(7'd0, 5'd0, 5'd3, 3'd0, 5'd10, 7'h33), 32'h404, 0, 1, 5'd3, 32'h1234_5678, "t5_same", st);
`ifdef WB_BYPASS_EN
        check("t5_bypass", rs1_data_ex, 32'h1234_5678);
`else
        check("t5_old_value", rs1_data_ex, 32'h1111_1111);
`endif
        step(32'h0000_0013, 32'h408, 0, 1, 5'd0, 32'hFFFF_FFFF, "t5_wx0", st);
        step(enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd11, 7'h33), 32'h40C, 0, 1, 5'd0, 32'hA5A5_A5A5, "t5_rx0", st);
        check("t5_x0", rs1_data_ex, 32'd0);

        step(enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd5, 7'h0B), 32'h500, 0, 0, 0, 0, "t6_rti", st);
        check("t6_rti", {31'd0, rti_ex}, 32'd1);
        step(enc(7'd0, 5'd0, 5'd0, 3'd1, 5'd5, 7'h0B), 32'h504, 0, 0, 0, 0, "t6_rsi", st);
        check("t6_rti_once", {31'd0, rti_ex}, 32'd0);
        check("t6_rsi", {31'd0, rsi_ex}, 32'd1);
        step(enc(7'd0, 5'd0, 5'd0, 3'd2, 5'd5, 7'h0B), 32'h508, 0, 0, 0, 0, "t6_bad", st);
        check("t6_bad_pc", pc_ex, 32'd0);

        hold = 0; cur_ins = 0; cur_pc = 0;
        for (int i = 0; i < 600; i++) begin
            bit fl;
            if (!hold) begin
                cur_ins = rand_insn();
                cur_pc  = $urandom & 32'hFFFF_FFFC;
            end
            fl = ($urandom_range(0, 9) == 0);
            step(cur_ins, cur_pc, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, "rnd", st);
            hold = st && !fl;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
